// File: rtl/zb_bb_pkg.sv
// Shared types for the baseband low-pass/decimation slice: sample width,
// IQ sample pair and the running-sum width helper.
package zb_bb_pkg;

  localparam int W_IN = 5;

  typedef logic signed [W_IN-1:0] sample_t;

  typedef struct packed {
    sample_t i;
    sample_t q;
  } iq_sample_t;

  // A sum of 2**log2_len samples needs log2_len extra bits to stay exact.
  function automatic int sum_width(input int log2_len);
    return W_IN + log2_len;
  endfunction

endpackage

// File: rtl/bb_lowpass_decim_if.sv
// Sample bus between the IQ demodulator, the low-pass/decimation stage and
// the chip-synchronisation stage.
interface bb_lowpass_decim_if;
  import zb_bb_pkg::*;

  logic    demod_rdy;
  sample_t I_BB;
  sample_t Q_BB;
  logic    lp_clr;
  sample_t I_LP;
  sample_t Q_LP;
  logic    lp_rdy;

  modport master (
    output demod_rdy, I_BB, Q_BB, lp_clr,
    input  I_LP, Q_LP, lp_rdy
  );

  modport slave (
    input  demod_rdy, I_BB, Q_BB, lp_clr,
    output I_LP, Q_LP, lp_rdy
  );

endinterface

// File: rtl/boxcar_channel.sv
// One channel of the moving-average filter: an L-tap delay line plus a
// running sum that always equals the exact total of the taps.
module boxcar_channel
  import zb_bb_pkg::*;
#(
  parameter int LOG2_LEN = 2
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    clr,
  input  logic    en,
  input  sample_t din,
  output sample_t avg
);

  localparam int L  = 1 << LOG2_LEN;
  localparam int SW = sum_width(LOG2_LEN);

  typedef logic signed [SW-1:0] sum_t;

  sample_t taps [L];
  sum_t    sum;

  // The sum adds the incoming sample and drops the tap that falls off the end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < L; k++) taps[k] <= '0;
      sum <= '0;
    end else if (clr) begin
      for (int k = 0; k < L; k++) taps[k] <= '0;
      sum <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int k = 1; k < L; k++) taps[k] <= taps[k-1];
      sum <= sum + sum_t'(din) - sum_t'(taps[L-1]);
    end
  end

  // Arithmetic shift floors toward -inf; the mean of W_IN-bit samples fits W_IN bits.
  assign avg = sample_t'(sum >>> LOG2_LEN);

endmodule

// File: rtl/bb_lowpass_decim.sv
// Baseband boxcar low-pass and decimator: two boxcar channels plus the
// window-fill / decimation control and the registered outputs.
module bb_lowpass_decim
  import zb_bb_pkg::*;
#(
  parameter int LOG2_LEN = 2,
  parameter int DECIM    = 2
) (
  input  logic                clk,
  input  logic                resetn,
  bb_lowpass_decim_if.slave   bus
);

  localparam int L  = 1 << LOG2_LEN;
  localparam int FW = $clog2(L + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [FW-1:0] FILL_FULL = FW'(L);
  localparam logic [FW-1:0] FILL_LAST = FW'(L - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);

  logic          accept;
  logic          primed;
  logic          emit_now;
  logic          emit_q;
  logic [FW-1:0] fill;
  logic [DW-1:0] dcnt;
  sample_t       avg_i;
  sample_t       avg_q;
  iq_sample_t    lp_q;
  logic          lp_rdy_q;

  // A clear in the same cycle as a valid sample discards that sample.
  assign accept   = bus.demod_rdy && !bus.lp_clr;
  assign primed   = (fill == FILL_FULL);
  assign emit_now = accept && ((fill == FILL_LAST) || (primed && (dcnt == DCNT_LAST)));

  boxcar_channel #(.LOG2_LEN(LOG2_LEN)) u_chan_i (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.lp_clr),
    .en     (accept),
    .din    (bus.I_BB),
    .avg    (avg_i)
  );

  boxcar_channel #(.LOG2_LEN(LOG2_LEN)) u_chan_q (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.lp_clr),
    .en     (accept),
    .din    (bus.Q_BB),
    .avg    (avg_q)
  );

  // The priming sample is emission index 0, so the decimation counter only
  // starts moving on accepts after the window is full.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill   <= '0;
      dcnt   <= '0;
      emit_q <= 1'b0;
    end else if (bus.lp_clr) begin
      fill   <= '0;
      dcnt   <= '0;
      emit_q <= 1'b0;
    end else begin
      emit_q <= emit_now;
      if (accept) begin
        if (!primed) begin
          fill <= fill + 1'b1;
        end else if (dcnt == DCNT_LAST) begin
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // Outputs are captured from the sums one edge after the emitting accept,
  // so a pending emission survives a clear arriving on that edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lp_q     <= '0;
      lp_rdy_q <= 1'b0;
    end else begin
      lp_rdy_q <= emit_q;
      if (emit_q) begin
        lp_q.i <= avg_i;
        lp_q.q <= avg_q;
      end
    end
  end

  assign bus.I_LP   = lp_q.i;
  assign bus.Q_LP   = lp_q.q;
  assign bus.lp_rdy = lp_rdy_q;

endmodule
